// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic ranging blocks: scheduler FSM encoding
// and default timing constants (50 MHz system clock).
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_DIVIDE,
        ST_REPORT,
        ST_GUARD
    } state_e;

    localparam int DEF_NUM_CH         = 2;
    localparam int DEF_TRIG_CYCLES    = 500;
    localparam int DEF_TIMEOUT_CYCLES = 1_500_000;
    localparam int DEF_GUARD_CYCLES   = 3_000_000;
    localparam int DEF_CYCLES_PER_CM  = 2900;
    localparam int DEF_MAX_CM         = 400;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/us_cycle_divider.sv
// Iterative subtract-divider: quotient = floor(dividend / DIVISOR), saturated at MAX_Q.
// One subtraction per cycle; done is a combinational strobe while busy and no step remains.
module us_cycle_divider #(
    parameter int DIV_W   = 21,
    parameter int DIVISOR = 2900,
    parameter int MAX_Q   = 400,
    parameter int Q_W     = $clog2(MAX_Q + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    logic [DIV_W-1:0] rem_q, rem_d;
    logic [Q_W-1:0]   q_q, q_d;
    logic             busy_q, busy_d;
    logic             step;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        rem_d  = rem_q;
        q_d    = q_q;
        busy_d = busy_q;
        step   = busy_q && (rem_q >= DIV_W'(DIVISOR)) && (q_q < Q_W'(MAX_Q));
        done   = busy_q && !step;
        if (start) begin
            rem_d  = dividend;
            q_d    = '0;
            busy_d = 1'b1;
        end else if (step) begin
            rem_d = rem_q - DIV_W'(DIVISOR);
            q_d   = q_q + Q_W'(1);
        end else if (busy_q) begin
            busy_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            q_q    <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            q_q    <= q_d;
            busy_q <= busy_d;
        end
    end

    assign quotient = q_q;

endmodule

// File: rtl/ultrasonic_scan_scheduler.sv
// Time-multiplexes one ranging engine across NUM_CH HC-SR04 sensors: trigger, echo
// timing, cycles-to-cm conversion and a guard gap, emitting one tagged result per shot.
module ultrasonic_scan_scheduler
    import ultrasonic_pkg::*;
#(
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
    parameter int CYCLES_PER_CM  = DEF_CYCLES_PER_CM,
    parameter int MAX_CM         = DEF_MAX_CM,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] echo,
    output logic [NUM_CH-1:0] trigger,
    output logic [15:0]       dist_cm,
    output logic [CH_W-1:0]   dist_ch,
    output logic              dist_timeout,
    output logic              dist_valid,
    output logic              scan_done,
    output logic              busy
);

    localparam int TIMER_W = $clog2(max3(TIMEOUT_CYCLES, GUARD_CYCLES, TRIG_CYCLES) + 1);
    localparam int Q_W     = $clog2(MAX_CM + 1);

    localparam logic [TIMER_W-1:0] TRIG_LAST  = TIMER_W'(TRIG_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_T  = TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] GUARD_LAST = TIMER_W'(GUARD_CYCLES - 1);

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [NUM_CH-1:0]   trigger_q, trigger_d;
    logic [15:0]         dist_cm_q, dist_cm_d;
    logic [CH_W-1:0]     dist_ch_q, dist_ch_d;
    logic                dist_timeout_q, dist_timeout_d;
    logic                dist_valid_q, dist_valid_d;
    logic                scan_done_q, scan_done_d;
    logic                busy_q, busy_d;

    logic [NUM_CH-1:0]   echo_meta_q, echo_sync_q;
    logic                echo_prev_q;
    logic                sel_echo, rise, fall;

    logic [CH_W-1:0]     next_ch, hi_ch;
    logic                found;
    logic                div_start, div_done;
    logic [Q_W-1:0]      div_quotient;
    logic                do_report, report_to;

    assign sel_echo = echo_sync_q[ch_q];
    assign rise     = sel_echo & ~echo_prev_q;
    assign fall     = ~sel_echo & echo_prev_q;

    // ptr_q is the first candidate to try, i.e. one past the last channel served.
    always_comb begin
        next_ch = '0;
        found   = 1'b0;
        hi_ch   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && ch_mask[(int'(ptr_q) + i) % NUM_CH]) begin
                next_ch = CH_W'((int'(ptr_q) + i) % NUM_CH);
                found   = 1'b1;
            end
            if (ch_mask[i]) hi_ch = CH_W'(i);
        end
    end

    us_cycle_divider #(
        .DIV_W   (TIMER_W),
        .DIVISOR (CYCLES_PER_CM),
        .MAX_Q   (MAX_CM),
        .Q_W     (Q_W)
    ) u_divider (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (timer_q),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        ch_d           = ch_q;
        ptr_d          = ptr_q;
        trigger_d      = trigger_q;
        dist_cm_d      = dist_cm_q;
        dist_ch_d      = dist_ch_q;
        dist_timeout_d = dist_timeout_q;
        dist_valid_d   = 1'b0;
        scan_done_d    = 1'b0;
        div_start      = 1'b0;
        do_report      = 1'b0;
        report_to      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable && (|ch_mask)) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (!enable || !(|ch_mask)) begin
                    state_d = ST_IDLE;
                end else begin
                    ch_d      = next_ch;
                    trigger_d = NUM_CH'(1) << next_ch;
                    timer_d   = '0;
                    state_d   = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (timer_q == TRIG_LAST) begin
                    trigger_d = '0;
                    timer_d   = '0;
                    state_d   = ST_WAIT_RISE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_WAIT_RISE: begin
                // The rise cycle itself is the first high cycle, so the width count starts at 1.
                if (rise) begin
                    timer_d = TIMER_W'(1);
                    state_d = ST_MEASURE;
                end else if (timer_q == TIMEOUT_T) begin
                    do_report = 1'b1;
                    report_to = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_MEASURE: begin
                if (timer_q == TIMEOUT_T) begin
                    do_report = 1'b1;
                    report_to = 1'b1;
                end else if (fall) begin
                    div_start = 1'b1;
                    state_d   = ST_DIVIDE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_DIVIDE: begin
                if (div_done) do_report = 1'b1;
            end
            ST_REPORT: begin
                ptr_d   = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
                timer_d = '0;
                state_d = ST_GUARD;
            end
            ST_GUARD: begin
                if (timer_q == GUARD_LAST) state_d = ST_SELECT;
                else                       timer_d = timer_q + TIMER_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // Results are loaded on entry to REPORT so the strobe coincides with the REPORT cycle.
        if (do_report) begin
            state_d        = ST_REPORT;
            dist_cm_d      = report_to ? 16'd0 : 16'(div_quotient);
            dist_ch_d      = ch_q;
            dist_timeout_d = report_to;
            dist_valid_d   = 1'b1;
            scan_done_d    = (ch_q == hi_ch);
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            ch_q           <= '0;
            ptr_q          <= '0;
            trigger_q      <= '0;
            dist_cm_q      <= '0;
            dist_ch_q      <= '0;
            dist_timeout_q <= 1'b0;
            dist_valid_q   <= 1'b0;
            scan_done_q    <= 1'b0;
            busy_q         <= 1'b0;
            echo_meta_q    <= '0;
            echo_sync_q    <= '0;
            echo_prev_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            ch_q           <= ch_d;
            ptr_q          <= ptr_d;
            trigger_q      <= trigger_d;
            dist_cm_q      <= dist_cm_d;
            dist_ch_q      <= dist_ch_d;
            dist_timeout_q <= dist_timeout_d;
            dist_valid_q   <= dist_valid_d;
            scan_done_q    <= scan_done_d;
            busy_q         <= busy_d;
            echo_meta_q    <= echo;
            echo_sync_q    <= echo_meta_q;
            echo_prev_q    <= sel_echo;
        end
    end

    assign trigger      = trigger_q;
    assign dist_cm      = dist_cm_q;
    assign dist_ch      = dist_ch_q;
    assign dist_timeout = dist_timeout_q;
    assign dist_valid   = dist_valid_q;
    assign scan_done    = scan_done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Directed bench for ultrasonic_scan_scheduler with short timing constants:
// TRIG=10, TIMEOUT=1000, GUARD=50, CYCLES_PER_CM=29, MAX_CM=400, two sensors.
module tb_ultrasonic_scan_scheduler;

    localparam int NUM_CH  = 2;
    localparam int TRIG    = 10;
    localparam int TIMEOUT = 1000;
    localparam int GUARD   = 50;
    localparam int CPC     = 29;
    localparam int MAXCM   = 400;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [NUM_CH-1:0] ch_mask;
    logic [NUM_CH-1:0] echo;
    logic [NUM_CH-1:0] trigger;
    logic [15:0]       dist_cm;
    logic [0:0]        dist_ch;
    logic              dist_timeout;
    logic              dist_valid;
    logic              scan_done;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int overlap_cnt  = 0;
    int ch1_trig_cnt = 0;
    int any_trig_cnt = 0;

    ultrasonic_scan_scheduler #(
        .NUM_CH         (NUM_CH),
        .TRIG_CYCLES    (TRIG),
        .TIMEOUT_CYCLES (TIMEOUT),
        .GUARD_CYCLES   (GUARD),
        .CYCLES_PER_CM  (CPC),
        .MAX_CM         (MAXCM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .ch_mask      (ch_mask),
        .echo         (echo),
        .trigger      (trigger),
        .dist_cm      (dist_cm),
        .dist_ch      (dist_ch),
        .dist_timeout (dist_timeout),
        .dist_valid   (dist_valid),
        .scan_done    (scan_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ($countones(trigger) > 1) overlap_cnt++;
        if (trigger[1])              ch1_trig_cnt++;
        if (trigger != '0)           any_trig_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // mode 0: echo pulse of 'width' cycles on exp_ch; mode 1: no echo; mode 2: echo left as the caller set it.
    task automatic run_shot(input string tag, input int exp_ch, input int mode, input int width,
                            input int drop_at, input int exp_cm, input bit exp_to, input bit exp_done,
                            output int trig_wait, output int strobe_cyc);
        int               hi;
        bit               seen;
        logic [15:0]      cm;
        logic             ch_o, to_o, done_o;
        logic [NUM_CH-1:0] exp_trig;
        exp_trig = '0;
        exp_trig[exp_ch] = 1'b1;
        cm = '0; ch_o = 1'b0; to_o = 1'b0; done_o = 1'b0;
        trig_wait = 0;
        while (trigger == '0 && trig_wait < 200) begin
            @(negedge clk);
            trig_wait++;
        end
        check({tag, "_trig"}, 32'(trigger), 32'(exp_trig));
        hi = 0;
        while (trigger != '0 && hi < 100) begin
            @(negedge clk);
            hi++;
        end
        check({tag, "_trig_len"}, hi, TRIG);
        seen = 1'b0;
        strobe_cyc = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!seen && dist_valid) begin
                seen = 1'b1;
                strobe_cyc = cyc;
                cm = dist_cm; ch_o = dist_ch; to_o = dist_timeout; done_o = scan_done;
            end
            if (cyc == drop_at) enable = 1'b0;
            if (mode == 0) echo[exp_ch] = (cyc >= 5 && cyc < 5 + width);
            if (seen && (mode != 0 || cyc >= 5 + width)) break;
        end
        if (mode == 0) echo = '0;
        check({tag, "_strobe_seen"}, 32'(seen), 1);
        check({tag, "_cm"},      32'(cm),     exp_cm);
        check({tag, "_ch"},      32'(ch_o),   exp_ch);
        check({tag, "_timeout"}, 32'(to_o),   32'(exp_to));
        check({tag, "_done"},    32'(done_o), 32'(exp_done));
    endtask

    initial begin
        int tw, sc, n, c1_0, any_0;

        rst = 1'b1; enable = 1'b0; ch_mask = '0; echo = '0;
        repeat (3) @(negedge clk);
        check("rst_trigger", 32'(trigger), 0);
        check("rst_valid",   32'(dist_valid), 0);
        check("rst_cm",      32'(dist_cm), 0);
        check("rst_busy",    32'(busy), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // Test 1: both sensors, round robin ch0 then ch1.
        ch_mask = 2'b11; enable = 1'b1;
        run_shot("t1_ch0", 0, 0, 290, -1, 10, 1'b0, 1'b0, tw, sc);
        run_shot("t1_ch1", 1, 0, 580, -1, 20, 1'b0, 1'b1, tw, sc);

        // Test 2: only ch0 enabled; division boundaries.
        ch_mask = 2'b01;
        c1_0 = ch1_trig_cnt;
        run_shot("t2_w28",  0, 0, 28,  -1, 0,  1'b0, 1'b1, tw, sc);
        run_shot("t2_w29",  0, 0, 29,  -1, 1,  1'b0, 1'b1, tw, sc);
        run_shot("t2_w999", 0, 0, 999, -1, 34, 1'b0, 1'b1, tw, sc);
        check("t2_ch1_never_triggered", ch1_trig_cnt - c1_0, 0);

        // Test 3: no echo at all.
        run_shot("t3_noecho", 0, 1, 0, -1, 0, 1'b1, 1'b1, tw, sc);
        check_range("t3_timeout_latency", sc, 998, 1004);

        // Test 4: echo high before trigger, then echo exactly TIMEOUT cycles long.
        echo[0] = 1'b1;
        run_shot("t4_held", 0, 2, 0, -1, 0, 1'b1, 1'b1, tw, sc);
        check_range("t3_guard_to_next_trigger", tw, 50, 55);
        echo = '0;
        run_shot("t4_long", 0, 0, 1000, -1, 0, 1'b1, 1'b1, tw, sc);

        // Test 5: enable dropped during MEASURE still reports, then goes idle after GUARD.
        ch_mask = 2'b11;
        run_shot("t5_drop", 1, 0, 290, 150, 10, 1'b0, 1'b1, tw, sc);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_range("t5_busy_fall", n, 50, 55);
        ch_mask = 2'b00; enable = 1'b1;
        any_0 = any_trig_cnt;
        repeat (100) @(negedge clk);
        check("t5_mask0_busy", 32'(busy), 0);
        check("t5_mask0_no_trigger", any_trig_cnt - any_0, 0);

        // Test 6: reset during ch1 trigger; scan restarts at ch0.
        ch_mask = 2'b11;
        run_shot("t6_ch0", 0, 0, 58, -1, 2, 1'b0, 1'b0, tw, sc);
        n = 0;
        while (trigger == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t6_ch1_trig", 32'(trigger), 2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_trigger", 32'(trigger), 0);
        check("t6_rst_cm",      32'(dist_cm), 0);
        check("t6_rst_ch",      32'(dist_ch), 0);
        check("t6_rst_to",      32'(dist_timeout), 0);
        check("t6_rst_valid",   32'(dist_valid), 0);
        check("t6_rst_done",    32'(scan_done), 0);
        check("t6_rst_busy",    32'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_shot("t6_restart", 0, 0, 290, -1, 10, 1'b0, 1'b0, tw, sc);

        check("trigger_overlap", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
